// File: rtl/intc_prio_pkg.sv
// intc_pkg: register offsets, widths and helpers shared by the interrupt controller
package intc_pkg;

    typedef enum logic [1:0] {
        REG_PEND  = 2'd0,
        REG_MASK  = 2'd1,
        REG_EDGE  = 2'd2,
        REG_VECID = 2'd3
    } reg_off_e;

    localparam int VEC_IDX_W   = 3;
    localparam int MAX_VECTORS = 8;

    // bits of a byte register that are backed by a real channel
    function automatic logic [7:0] chan_mask(input int n);
        return 8'((1 << n) - 1);
    endfunction

endpackage

// File: rtl/intc_prio_if.sv
// intc_prio_if: core data-bus and vectoring signals between the core and the controller
interface intc_prio_if;
    import intc_pkg::*;

    logic [15:0]          address_i;
    logic                 wr_en_i;
    logic [7:0]           wdata_i;
    logic [7:0]           rdata_o;
    logic                 intack_i;
    logic                 int_o;
    logic                 vec_valid_o;
    logic [VEC_IDX_W-1:0] vec_idx_o;

    modport master (
        output address_i, wr_en_i, wdata_i, intack_i,
        input  rdata_o, int_o, vec_valid_o, vec_idx_o
    );

    modport slave (
        input  address_i, wr_en_i, wdata_i, intack_i,
        output rdata_o, int_o, vec_valid_o, vec_idx_o
    );

endinterface

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational fixed-priority encoder, lowest index wins
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int N = MAX_VECTORS
) (
    input  logic [N-1:0]         req,
    output logic                 valid,
    output logic [VEC_IDX_W-1:0] idx
);

    // scan from the top down so the lowest set index is the last one written
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = VEC_IDX_W'(i);
    end

endmodule

// File: rtl/intc_prio.sv
// intc_prio: synchronised, maskable, edge/level interrupt controller with fixed-priority vector
module intc_prio
    import intc_pkg::*;
#(
    parameter int          NUM_VECTORS = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h00EC,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  MASK_RST    = 8'h00,
    parameter logic [7:0]  EDGE_RST    = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    intc_prio_if.slave             bus,
    input  logic [NUM_VECTORS-1:0] vector_i
);

    localparam logic [7:0] VMASK = chan_mask(NUM_VECTORS);

    logic [15:0]          off;
    logic                 hit;
    logic                 wr_pend;
    logic                 wr_mask;
    logic                 wr_edge;
    logic                 ack;
    logic [7:0]           s;
    logic [7:0]           p_q;
    logic [7:0]           set_v;
    logic [7:0]           clr_v;
    logic [7:0]           pend_q;
    logic [7:0]           mask_q;
    logic [7:0]           edge_q;
    logic [7:0]           act;
    logic                 enc_valid;
    logic [VEC_IDX_W-1:0] enc_idx;

    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic [NUM_VECTORS-1:0] q;
        if (g == 0) begin : g_first
            // first stage samples the asynchronous sources
            always_ff @(posedge clk)
                q <= reset_n ? vector_i : '0;
        end else begin : g_next
            // later stages settle metastability
            always_ff @(posedge clk)
                q <= reset_n ? g_sync[g-1].q : '0;
        end
    end

    assign s = 8'(g_sync[SYNC_STAGES-1].q);

    // edge history; cleared on reset so an input high at reset exit counts as one edge
    always_ff @(posedge clk)
        p_q <= reset_n ? s : '0;

    // address decode, set/clear terms; acks use the registered index the core saw
    always_comb begin
        off     = bus.address_i - BASE_ADDR;
        hit     = off < 16'd4;
        wr_pend = bus.wr_en_i && hit && off[1:0] == REG_PEND;
        wr_mask = bus.wr_en_i && hit && off[1:0] == REG_MASK;
        wr_edge = bus.wr_en_i && hit && off[1:0] == REG_EDGE;
        ack     = bus.intack_i && bus.vec_valid_o;
        set_v   = s & ~(edge_q & p_q) & VMASK;
        clr_v   = (wr_pend ? bus.wdata_i : 8'h00) | (ack ? 8'd1 << bus.vec_idx_o : 8'h00);
        act     = pend_q & mask_q;
    end

    // register file; set is applied after clear so a simultaneous event is never lost
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_q <= 8'h00;
            mask_q <= MASK_RST & VMASK;
            edge_q <= EDGE_RST & VMASK;
        end else begin
            pend_q <= ((pend_q & ~clr_v) | set_v) & VMASK;
            if (wr_mask) mask_q <= bus.wdata_i & VMASK;
            if (wr_edge) edge_q <= bus.wdata_i & VMASK;
        end
    end

    intc_prio_enc #(.N(MAX_VECTORS)) u_enc (
        .req   (act),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // registered request and vector towards the core
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.int_o       <= 1'b0;
            bus.vec_valid_o <= 1'b0;
            bus.vec_idx_o   <= '0;
        end else begin
            bus.int_o       <= enc_valid;
            bus.vec_valid_o <= enc_valid;
            bus.vec_idx_o   <= enc_idx;
        end
    end

    // side-effect-free read mux
    always_comb
        bus.rdata_o = !hit                  ? 8'h00 :
                      off[1:0] == REG_PEND  ? pend_q :
                      off[1:0] == REG_MASK  ? mask_q :
                      off[1:0] == REG_EDGE  ? edge_q :
                                              {bus.vec_valid_o, 4'b0000, bus.vec_idx_o};

endmodule
